// File: rtl/mux_2x1_pkg.sv
// Shared select encoding and default data width for mux_2x1 and its instantiators.
package mux_2x1_pkg;

  localparam int unsigned MUX_2X1_WIDTH = 4;

  typedef enum logic {
    SEL_IN1 = 1'b0,
    SEL_IN2 = 1'b1
  } sel_e;

endpackage

// File: rtl/mux_2x1_reg.sv
// WIDTH-bit register with asynchronous active-low reset to RST_VAL and a valid flag
// that rises on the first clock edge after reset is released.
module mux_2x1_reg #(
  parameter int unsigned     WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q;
  logic             vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= d_i;
      vld_q  <= 1'b1;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/mux_2x1.sv
// Two-input WIDTH-bit selector with combinational and registered outputs.
// Define MUX_2X1_SEL_CNT_EN to add the saturating select-toggle counter output sel_cnt.
module mux_2x1
  import mux_2x1_pkg::*;
#(
  parameter int unsigned      WIDTH   = MUX_2X1_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             select,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_vld
`ifdef MUX_2X1_SEL_CNT_EN
  ,
  output logic [15:0]      sel_cnt
`endif
);

  // Equality compare keeps an X/Z select propagating to out instead of defaulting to in1.
  assign out = (select == SEL_IN2) ? in2 : in1;

  mux_2x1_reg #(
    .WIDTH  (WIDTH),
    .RST_VAL(RST_VAL)
  ) u_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (out),
    .q_o  (out_q),
    .vld_o(out_vld)
  );

`ifdef MUX_2X1_SEL_CNT_EN
  sel_e        sel_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_IN1;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_e'(select);
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((sel_q != sel_e'(select)) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign sel_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_2x1.sv
// Directed vector table plus randomized run against an array-indexed reference model.
module tb_mux_2x1;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         select;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W-1:0] out;
  logic [W-1:0] out_q;
  logic         out_vld;
`ifdef MUX_2X1_SEL_CNT_EN
  logic [15:0]  sel_cnt;
`endif

  int unsigned vec_cnt;
  int unsigned err_cnt;

  mux_2x1 #(
    .WIDTH  (W),
    .RST_VAL(4'b0000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .select (select),
    .in1    (in1),
    .in2    (in2),
    .out    (out),
    .out_q  (out_q),
    .out_vld(out_vld)
`ifdef MUX_2X1_SEL_CNT_EN
    ,
    .sel_cnt(sel_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         do_clk;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_q;
    logic         exp_vld;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_mux(input logic s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] ins [2];
    ins[0] = a;
    ins[1] = b;
    return ins[s];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t         vecs [11];
  logic [W-1:0] exp_q;
  logic         exp_vld;
  logic [W-1:0] hold_out;

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b1;
    select  = 1'b0;
    in1     = '0;
    in2     = '0;
    #1 rst_n = 1'b0;

    //        rst  sel  in1      in2      clk   out      out_q    vld
    vecs[0]  = '{1'b0, 1'b0, 4'b0011, 4'b1011, 1'b0, 4'b0011, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'b0011, 4'b1011, 1'b1, 4'b0011, 4'b0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'b0010, 4'b1011, 1'b0, 4'b1011, 4'b0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'b0010, 4'b1011, 1'b1, 4'b1011, 4'b1011, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 4'b1111, 4'b1110, 1'b0, 4'b1111, 4'b1011, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 4'b1111, 4'b1110, 1'b1, 4'b1111, 4'b1111, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 4'b1100, 4'b0011, 1'b1, 4'b0011, 4'b0011, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 4'b1100, 4'b0011, 1'b0, 4'b1100, 4'b0011, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 4'b1100, 4'b0011, 1'b1, 4'b1100, 4'b1100, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 4'b0101, 4'b0101, 1'b1, 4'b0101, 4'b0101, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 4'b0101, 4'b0101, 1'b0, 4'b0101, 4'b0101, 1'b1};

    #2;
    for (int i = 0; i < 11; i++) begin
      rst_n  = vecs[i].rst_n;
      select = vecs[i].sel;
      in1    = vecs[i].a;
      in2    = vecs[i].b;
      #1;
      check($sformatf("vec%0d_out", i), 16'(out), 16'(vecs[i].exp_out));
      if (vecs[i].do_clk) step();
      check($sformatf("vec%0d_out_q", i), 16'(out_q), 16'(vecs[i].exp_q));
      check($sformatf("vec%0d_vld", i), 16'(out_vld), 16'(vecs[i].exp_vld));
    end

    // Reset asserted between edges clears the register at once; out keeps tracking.
    select = 1'b1; in1 = 4'b1001; in2 = 4'b0110;
    step();
    check("midrst_pre_q", 16'(out_q), 16'(4'b0110));
    hold_out = out;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_q", 16'(out_q), 16'(4'b0000));
    check("midrst_vld", 16'(out_vld), 16'(1'b0));
    check("midrst_out", 16'(out), 16'(hold_out));
    select = 1'b0;
    #1;
    check("midrst_out_track", 16'(out), 16'(4'b1001));
    step();
    check("rst_hold_q", 16'(out_q), 16'(4'b0000));
    #1 rst_n = 1'b1;
    #1;
    check("rel_before_edge_vld", 16'(out_vld), 16'(1'b0));
    step();
    check("rel_after_edge_q", 16'(out_q), 16'(4'b1001));
    check("rel_after_edge_vld", 16'(out_vld), 16'(1'b1));

    // Randomized run; expected register state advances only on clocked edges out of reset.
    exp_q   = out_q;
    exp_vld = out_vld;
    for (int c = 0; c < 300; c++) begin
      select = 1'($urandom);
      in1    = W'($urandom);
      in2    = W'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        exp_q = 4'b0000;
        exp_vld = 1'b0;
      end else begin
        rst_n = 1'b1;
      end
      #1;
      check("rnd_out", 16'(out), 16'(ref_mux(select, in1, in2)));
      check("rnd_q_pre", 16'(out_q), 16'(exp_q));
      if (rst_n) begin
        exp_q   = ref_mux(select, in1, in2);
        exp_vld = 1'b1;
      end
      step();
      check("rnd_q", 16'(out_q), 16'(exp_q));
      check("rnd_vld", 16'(out_vld), 16'(exp_vld));
    end

`ifdef MUX_2X1_SEL_CNT_EN
    rst_n  = 1'b0;
    select = 1'b0;
    #1;
    check("cnt_rst", sel_cnt, 16'd0);
    rst_n = 1'b1;
    step();
    for (int t = 0; t < 5; t++) begin
      select = ~select;
      step();
    end
    check("cnt_5_toggles", sel_cnt, 16'd5);
    step();
    check("cnt_hold", sel_cnt, 16'd5);
    #1 rst_n = 1'b0;
    #1;
    check("cnt_cleared", sel_cnt, 16'd0);
    rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
